aes256_key_sched_ctrl: RTL and testbench

Sequencer and round-key store for the AES-256 key-expansion datapath. Accepts a 256-bit cipher key over a valid/ready handshake and latches it onto the expansion block's key input. Steps the expansion block's round input 0..14, captures each 128-bit round key into a 15-entry buffer, and serves the buffered keys to the cipher rounds through a registered read port.

---
 rtl/aes256_key_sched_ctrl.sv | 166 ++++++++++++++++
 tb/tb_aes256_key_sched_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 key-expansion sequencer: latches the cipher key, steps the round index,
// buffers the 15 round keys and serves them through a registered read port.
// Optional per-byte parity on the buffer: define KEYSCHED_PARITY_EN.
module aes256_key_sched_ctrl #(
    parameter int unsigned KEY_WIDTH = 256,
    parameter int unsigned NUM_RK    = 15,
    parameter int unsigned STEP_CYC  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   key_valid_i,
    output logic                   key_ready_o,
    input  logic [KEY_WIDTH-1:0]   key_i,
    input  logic                   abort_i,
    output logic [KEY_WIDTH-1:0]   ke_key_o,
    output logic [3:0]             ke_round_o,
    input  logic [KEY_WIDTH/2-1:0] ke_round_key_i,
    output logic                   busy_o,
    output logic                   keys_vld_o,
    input  logic                   rk_rd_i,
    input  logic [3:0]             rk_idx_i,
    output logic [KEY_WIDTH/2-1:0] rk_o,
    output logic                   rk_rd_vld_o,
    output logic                   rk_rd_err_o
`ifdef KEYSCHED_PARITY_EN
    ,
    output logic                   par_err_o
`endif
);

    localparam int unsigned RK_W       = KEY_WIDTH / 2;
    localparam logic [3:0]  LAST_RND   = 4'(NUM_RK - 1);
    localparam logic [1:0]  DWELL_LAST = 2'(STEP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        dwell;
    logic              handshake;
    logic              cap_en;
    logic [RK_W-1:0]   rk_buf [NUM_RK];

    assign key_ready_o = (state == IDLE) || (state == DONE);
    // abort wins over a handshake offered on the same edge
    assign handshake   = key_valid_i && key_ready_o && !abort_i;
    assign cap_en      = (state == RUN) && !abort_i && (dwell == DWELL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ke_key_o   <= '0;
            ke_round_o <= '0;
            dwell      <= '0;
            busy_o     <= 1'b0;
            keys_vld_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        ke_key_o   <= key_i;
                        ke_round_o <= '0;
                        dwell      <= '0;
                        busy_o     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        ke_round_o <= '0;
                        dwell      <= '0;
                        busy_o     <= 1'b0;
                        keys_vld_o <= 1'b0;
                        state      <= IDLE;
                    end else if (dwell == DWELL_LAST) begin
                        if (ke_round_o == LAST_RND) begin
                            busy_o     <= 1'b0;
                            keys_vld_o <= 1'b1;
                            state      <= DONE;
                        end else begin
                            ke_round_o <= ke_round_o + 4'd1;
                            dwell      <= '0;
                        end
                    end else begin
                        dwell <= dwell + 2'd1;
                    end
                end
                DONE: begin
                    if (abort_i) begin
                        keys_vld_o <= 1'b0;
                        state      <= IDLE;
                    end else if (handshake) begin
                        ke_key_o   <= key_i;
                        ke_round_o <= '0;
                        dwell      <= '0;
                        busy_o     <= 1'b1;
                        keys_vld_o <= 1'b0;
                        state      <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en) begin
            rk_buf[ke_round_o] <= ke_round_key_i;
        end
    end

`ifdef KEYSCHED_PARITY_EN
    localparam int unsigned NB = RK_W / 8;

    logic [NB-1:0] par_buf [NUM_RK];

    // One bit per byte that makes byte+bit even parity.
    function automatic logic [NB-1:0] byte_par(input logic [RK_W-1:0] d);
        logic [NB-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            p[i] = ^d[i*8 +: 8];
        end
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (cap_en) begin
            par_buf[ke_round_o] <= byte_par(ke_round_key_i);
        end
    end
`endif

    // Read port samples keys_vld_o before the edge, so a read racing a restart/abort sees the old buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_o        <= '0;
            rk_rd_vld_o <= 1'b0;
            rk_rd_err_o <= 1'b0;
`ifdef KEYSCHED_PARITY_EN
            par_err_o   <= 1'b0;
`endif
        end else begin
            rk_rd_vld_o <= rk_rd_i;
            rk_rd_err_o <= 1'b0;
            if (rk_rd_i) begin
                if (keys_vld_o && (rk_idx_i <= LAST_RND)) begin
                    rk_o <= rk_buf[rk_idx_i];
`ifdef KEYSCHED_PARITY_EN
                    if (byte_par(rk_buf[rk_idx_i]) != par_buf[rk_idx_i]) begin
                        rk_rd_err_o <= 1'b1;
                        par_err_o   <= 1'b1;
                    end
`endif
                end else begin
                    rk_o        <= '0;
                    rk_rd_err_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Directed bench for aes256_key_sched_ctrl: models the expansion block with
// FIPS-197 C.3 round keys and checks sequencing, latency, reads, abort and reset.
module tb_aes256_key_sched_ctrl;

    localparam logic [255:0] KEY_A =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_B =
        256'h13579bdf2468ace013579bdf2468ace0fedcba9876543210a5a55a5a3c3cc3c3;

    localparam logic [127:0] KA_RK [16] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'h101112131415161718191a1b1c1d1e1f,
        128'ha573c29fa176c498a97fce93a572c09c,
        128'h1651a8cd0244beda1a5da4c10640bade,
        128'hae87dff00ff11b68a68ed5fb03fc1567,
        128'h6de1f1486fa54f9275f8eb5373b8518d,
        128'hc656827fc9a799176f294cec6cd5598b,
        128'h3de23a75524775e727bf9eb45407cf39,
        128'h0bdc905fc27b0948ad5245a4c1871c2f,
        128'h45f5a66017b2d387300d4d33640a820a,
        128'h7ccff71cbeb4fe5413e6bbf0d261a7df,
        128'hf01afafee7a82979d7a5644ab3afe640,
        128'h2541fe719bf500258813bbd55a721c0a,
        128'h4e5a6699a9f24fe07e572baacdf8cdea,
        128'h24fc79ccbf0979e9371ac23c6d68de36,
        128'h0
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic         kv, abort, rd;
    logic [255:0] key;
    logic [3:0]   idx;
    logic         key_ready, busy, keys_vld, rd_vld, rd_err;
    logic [255:0] ke_key;
    logic [3:0]   ke_round;
    logic [127:0] ke_rk, rk;

    logic         kv3, abort3, rd3;
    logic [3:0]   idx3;
    logic         key_ready3, busy3, keys_vld3, rd_vld3, rd_err3;
    logic [255:0] ke_key3;
    logic [3:0]   ke_round3;
    logic [127:0] ke_rk3, rk3;

`ifdef KEYSCHED_PARITY_EN
    logic         par_err, par_err3;
`endif

    int unsigned  n_checks = 0;
    int unsigned  n_fails  = 0;

    always #5 clk = ~clk;

    // Expansion-block stand-in: real FIPS-197 schedule for KEY_A, a distinct pattern otherwise.
    function automatic logic [127:0] exp_rk(input logic [255:0] k, input logic [3:0] r);
        if (k == KEY_A) return KA_RK[r];
        return k[127:0] ^ {16{r, 4'h5}};
    endfunction

    always_comb ke_rk  = exp_rk(ke_key, ke_round);
    always_comb ke_rk3 = exp_rk(ke_key3, ke_round3);

    aes256_key_sched_ctrl u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .key_valid_i    (kv),
        .key_ready_o    (key_ready),
        .key_i          (key),
        .abort_i        (abort),
        .ke_key_o       (ke_key),
        .ke_round_o     (ke_round),
        .ke_round_key_i (ke_rk),
        .busy_o         (busy),
        .keys_vld_o     (keys_vld),
        .rk_rd_i        (rd),
        .rk_idx_i       (idx),
        .rk_o           (rk),
        .rk_rd_vld_o    (rd_vld),
        .rk_rd_err_o    (rd_err)
`ifdef KEYSCHED_PARITY_EN
        ,
        .par_err_o      (par_err)
`endif
    );

    aes256_key_sched_ctrl #(.STEP_CYC(3)) u_dut3 (
        .clk            (clk),
        .rst_n          (rst_n),
        .key_valid_i    (kv3),
        .key_ready_o    (key_ready3),
        .key_i          (key),
        .abort_i        (abort3),
        .ke_key_o       (ke_key3),
        .ke_round_o     (ke_round3),
        .ke_round_key_i (ke_rk3),
        .busy_o         (busy3),
        .keys_vld_o     (keys_vld3),
        .rk_rd_i        (rd3),
        .rk_idx_i       (idx3),
        .rk_o           (rk3),
        .rk_rd_vld_o    (rd_vld3),
        .rk_rd_err_o    (rd_err3)
`ifdef KEYSCHED_PARITY_EN
        ,
        .par_err_o      (par_err3)
`endif
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_read(input logic [3:0] i, input logic [127:0] exp_d, input logic exp_e);
        rd  = 1'b1;
        idx = i;
        tick();
        rd  = 1'b0;
        check($sformatf("rd%0d_vld", i), 256'(rd_vld), 256'(1));
        check($sformatf("rd%0d_err", i), 256'(rd_err), 256'(exp_e));
        check($sformatf("rd%0d_data", i), 256'(rk), 256'(exp_d));
    endtask

    // Called on the negedge right after the handshake edge.
    task automatic wait_done(input int unsigned cyc);
        repeat (cyc - 1) tick();
        check("done_early", 256'(keys_vld), 256'(0));
        tick();
        check("done_rise", 256'(keys_vld), 256'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; kv = 1'b0; abort = 1'b0; rd = 1'b0; key = '0; idx = '0;
        kv3 = 1'b0; abort3 = 1'b0; rd3 = 1'b0; idx3 = '0;
        repeat (2) tick();
        check("rst_ke_key", ke_key, 256'(0));
        check("rst_round", 256'(ke_round), 256'(0));
        check("rst_rk", 256'(rk), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_keys_vld", 256'(keys_vld), 256'(0));
        check("rst_rd_vld", 256'(rd_vld), 256'(0));
        check("rst_rd_err", 256'(rd_err), 256'(0));
        check("rst_ready", 256'(key_ready), 256'(1));
        rst_n = 1'b1;
        tick();

        // Read before any expansion is rejected.
        do_read(4'd3, 128'h0, 1'b1);

        // Key A, single-cycle dwell.
        kv = 1'b1; key = KEY_A;
        tick();
        kv = 1'b0;
        check("a_busy", 256'(busy), 256'(1));
        check("a_ready", 256'(key_ready), 256'(0));
        check("a_ke_key", ke_key, KEY_A);
        for (int r = 0; r < 15; r++) begin
            check($sformatf("a_round%0d", r), 256'(ke_round), 256'(r));
            if (r == 14) check("a_vld_early", 256'(keys_vld), 256'(0));
            tick();
        end
        check("a_vld", 256'(keys_vld), 256'(1));
        check("a_busy_done", 256'(busy), 256'(0));
        check("a_round_hold", 256'(ke_round), 256'(14));
        check("a_ready_done", 256'(key_ready), 256'(1));
        do_read(4'd0, KA_RK[0], 1'b0);
        do_read(4'd1, KA_RK[1], 1'b0);
        do_read(4'd14, KA_RK[14], 1'b0);
        do_read(4'd15, 128'h0, 1'b1);

        // Back-to-back reads, then rk_o holds with pulses dropped.
        rd = 1'b1; idx = 4'd5;
        tick();
        check("b2b_5", 256'(rk), 256'(KA_RK[5]));
        idx = 4'd6;
        tick();
        rd = 1'b0;
        check("b2b_6", 256'(rk), 256'(KA_RK[6]));
        check("b2b_6_vld", 256'(rd_vld), 256'(1));
        tick();
        check("idle_vld", 256'(rd_vld), 256'(0));
        check("idle_err", 256'(rd_err), 256'(0));
        check("idle_hold", 256'(rk), 256'(KA_RK[6]));

        // Restart with key B while reading A's round 14 on the same edge.
        kv = 1'b1; key = KEY_B; rd = 1'b1; idx = 4'd14;
        tick();
        kv = 1'b0; rd = 1'b0;
        check("rs_rd_vld", 256'(rd_vld), 256'(1));
        check("rs_rd_err", 256'(rd_err), 256'(0));
        check("rs_rd_data", 256'(rk), 256'(KA_RK[14]));
        check("rs_vld_drop", 256'(keys_vld), 256'(0));
        check("rs_ke_key", ke_key, KEY_B);
        wait_done(15);
        do_read(4'd0, exp_rk(KEY_B, 4'd0), 1'b0);
        do_read(4'd7, exp_rk(KEY_B, 4'd7), 1'b0);

        // Abort at round 6.
        kv = 1'b1; key = KEY_A;
        tick();
        kv = 1'b0;
        repeat (6) tick();
        check("ab_round6", 256'(ke_round), 256'(6));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_ready", 256'(key_ready), 256'(1));
        check("ab_busy", 256'(busy), 256'(0));
        check("ab_round", 256'(ke_round), 256'(0));
        do_read(4'd2, 128'h0, 1'b1);
        repeat (3) tick();
        check("ab_vld_low", 256'(keys_vld), 256'(0));
        kv = 1'b1; key = KEY_B;
        tick();
        kv = 1'b0;
        wait_done(15);
        do_read(4'd14, exp_rk(KEY_B, 4'd14), 1'b0);

        // key_valid held through RUN with a changing key, then async reset at round 9.
        kv = 1'b1; key = KEY_A;
        tick();
        for (int i = 1; i <= 9; i++) begin
            key = KEY_B ^ 256'(i);
            tick();
            check($sformatf("hold_ready%0d", i), 256'(key_ready), 256'(0));
            check($sformatf("hold_key%0d", i), ke_key, KEY_A);
        end
        check("hold_round9", 256'(ke_round), 256'(9));
        #1 rst_n = 1'b0;
        kv = 1'b0;
        #1;
        check("ar_ke_key", ke_key, 256'(0));
        check("ar_round", 256'(ke_round), 256'(0));
        check("ar_busy", 256'(busy), 256'(0));
        check("ar_keys_vld", 256'(keys_vld), 256'(0));
        check("ar_rk", 256'(rk), 256'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // STEP_CYC=3 instance: each round held 3 cycles, done 45 cycles after the handshake.
        kv3 = 1'b1; key = KEY_A;
        tick();
        kv3 = 1'b0;
        for (int r = 0; r < 15; r++) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("s3_round%0d_%0d", r, k), 256'(ke_round3), 256'(r));
                if (r == 14 && k == 2) check("s3_vld_early", 256'(keys_vld3), 256'(0));
                tick();
            end
        end
        check("s3_vld", 256'(keys_vld3), 256'(1));
        for (int i = 0; i < 15; i++) begin
            rd3 = 1'b1; idx3 = 4'(i);
            tick();
            rd3 = 1'b0;
            check($sformatf("s3_rd%0d", i), 256'({rd_vld3, rd_err3, rk3}), 256'({2'b10, KA_RK[i]}));
        end

`ifdef KEYSCHED_PARITY_EN
        check("par_err", 256'(par_err), 256'(0));
        check("par_err3", 256'(par_err3), 256'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
